// File: rtl/branch_pkg.sv
// Shared definitions for the registered branch-condition unit.
// Condition-code encodings and FSM state type.
package branch_pkg;

    localparam logic [3:0] BRZR = 4'b0000;
    localparam logic [3:0] BRNZ = 4'b0001;
    localparam logic [3:0] BRPL = 4'b0010;
    localparam logic [3:0] BRMI = 4'b0011;
    localparam logic [3:0] BRGE = 4'b0100;
    localparam logic [3:0] BRLE = 4'b0101;
    localparam logic [3:0] BRAL = 4'b0110;
    localparam logic [3:0] BRNV = 4'b0111;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a branch condition on a signed operand.
// Codes 4'b1xxx are undefined: result 0 and illegal raised.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [3:0]            cond,
    output logic                  result,
    output logic                  illegal
);

    logic zero;
    logic neg;

    assign zero = (d == '0);
    assign neg  = d[DATA_WIDTH-1];

    // decode condition code into taken/illegal
    always_comb begin
        result  = 1'b0;
        illegal = 1'b0;
        case (cond)
            BRZR:    result = zero;
            BRNZ:    result = !zero;
            BRPL:    result = !zero && !neg;
            BRMI:    result = neg;
            BRGE:    result = !neg;
            BRLE:    result = zero || neg;
            BRAL:    result = 1'b1;
            BRNV:    result = 1'b0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Registered branch-taken flag with valid/ack handshake, flush,
// sticky error flags and saturating taken/not-taken counters.
module branch_cond_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IR_WIDTH   = 32,
    parameter int COND_LSB   = 19,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] d,
    input  logic [IR_WIDTH-1:0]   IR_Data,
    input  logic                  ConFF_In,
    input  logic                  pc_ack,
    input  logic                  flush,
    output logic                  q,
    output logic                  q_valid,
    output logic                  illegal_cond,
    output logic                  overrun,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [CNT_WIDTH-1:0]  not_taken_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t     state;
    state_t     next_state;
    logic [3:0] cond;
    logic       result;
    logic       illegal;
    logic       load;
    logic       ovr_set;
    logic       unused_ir;

    assign cond      = IR_Data[COND_LSB+3:COND_LSB];
    assign unused_ir = ^IR_Data;
    assign q_valid   = (state == HOLD);

    branch_cond_eval #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_eval (
        .d      (d),
        .cond   (cond),
        .result (result),
        .illegal(illegal)
    );

    // state register
    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= next_state;
    end

    // next state, accept and overrun decisions; flush wins over all
    always_comb begin
        next_state = state;
        load       = 1'b0;
        ovr_set    = 1'b0;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ConFF_In) begin
                        load       = 1'b1;
                        next_state = HOLD;
                    end
                end
                HOLD: begin
                    if (pc_ack && ConFF_In) begin
                        load = 1'b1;
                    end else if (pc_ack) begin
                        next_state = IDLE;
                    end else if (ConFF_In) begin
                        ovr_set = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // taken flag: cleared by flush, loaded on accepted evaluation
    always_ff @(posedge clock or posedge clear) begin
        if (clear)      q <= 1'b0;
        else if (flush) q <= 1'b0;
        else if (load)  q <= result;
    end

    // sticky error flags, cleared only by reset
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            illegal_cond <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (load && illegal) illegal_cond <= 1'b1;
            if (ovr_set)         overrun      <= 1'b1;
        end
    end

    // saturating statistics counters
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (load) begin
            if (result && !(&taken_count))
                taken_count <= taken_count + CNT_ONE;
            if (!result && !(&not_taken_count))
                not_taken_count <= not_taken_count + CNT_ONE;
        end
    end

endmodule
